sd_cmd_tx: RTL and testbench

Controller that frames and transmits a 48-bit SD command token on the CMD line. It accepts a command index and 32-bit argument over a valid/ready handshake. It sequences a bit-serial CRC7 engine over the first 40 bits, then appends the CRC7 and end bit. It sits between the card-control FSM and the CMD pad and owns the bit-rate divider and the inter-command gap.

---
 rtl/sd_cmd_tx_pkg.sv | 37 +++
 rtl/sd_cmd_tx_if.sv | 35 +++
 rtl/sd_cmd_tx_crc7.sv | 37 +++
 rtl/sd_cmd_tx.sv | 160 ++++++++++++++++
 tb/tb_sd_cmd_tx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sd_cmd_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_pkg (package)
// Description : Shared constants, FSM state encoding and the CRC7 step
//               function for the SD CMD-line transmitter slice.
//               SD_CMD_BITS  - total token length on the CMD line
//               SD_HDR_BITS  - start + direction + index + argument
//               SD_CRC7_POLY - x^7 + x^3 + 1 (implicit x^7 term dropped)
// Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

    localparam int          SD_CMD_BITS  = 48;
    localparam int          SD_HDR_BITS  = 40;
    localparam int          SD_IDX_W     = 6;
    localparam int          SD_ARG_W     = 32;
    localparam logic [6:0]  SD_CRC7_POLY = 7'h09;

    // Explicit 3-bit encoding so the state register width is fixed.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        CRC  = 3'd2,
        STOP = 3'd3,
        GAP  = 3'd4
    } sd_state_e;

    // One serial CRC7 step: shift left, fold the polynomial in when the
    // incoming bit differs from the outgoing MSB.
    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic bit_in);
        logic inv;
        inv = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (inv ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_cmd_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_tx_if (interface)
// Description : Command request handshake between the card-control FSM
//               (master) and the CMD transmitter (slave).
//               req_valid - request valid        (master -> slave)
//               req_index - 6-bit command index  (master -> slave)
//               req_arg   - 32-bit argument      (master -> slave)
//               req_ready - transmitter idle     (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_cmd_tx_if;
    import sd_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [SD_IDX_W-1:0] req_index;
    logic [SD_ARG_W-1:0] req_arg;

    modport master (
        output req_valid,
        output req_index,
        output req_arg,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_index,
        input  req_arg,
        output req_ready
    );

endinterface
`default_nettype wire

// File: rtl/sd_cmd_tx_crc7.sv
`default_nettype none
// ============================================================================
// Module      : crc7_sync
// Description : Single-clock bit-serial CRC7 LFSR (x^7 + x^3 + 1, init 0).
//               clk    - system clock
//               rst    - synchronous active-high reset
//               clr    - synchronous clear to zero (start of a frame)
//               en     - advance the LFSR by one bit
//               bit_in - serial data bit
//               crc    - current CRC register
// Revision    : 1.0 - initial release
// ============================================================================
module crc7_sync
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic [6:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_crc <= 7'h00;
        end else if (en) begin
            r_crc <= crc7_next(r_crc, bit_in);
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/sd_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_tx
// Description : Frames and serialises a 48-bit SD command token on the CMD
//               line: start bit, direction bit, index, argument, CRC7, end
//               bit, followed by an idle gap of GAP_BITS bit-times.
//               clk       - system clock
//               rst       - synchronous active-high reset
//               req       - request handshake (slave modport)
//               cmd_out   - serial CMD data, MSB first
//               cmd_oe    - CMD pad output enable
//               busy      - frame or gap in progress
//               done      - one-cycle pulse after the end bit completes
//               crc_last  - CRC7 of the last completed frame
//               CLK_DIV   - clk cycles per SD bit (2..256)
//               GAP_BITS  - idle bit-times after the end bit
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int GAP_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    sd_cmd_tx_if.slave  req,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        busy,
    output logic        done,
    output logic [6:0]  crc_last
);

    localparam int c_DIV_W = $clog2(CLK_DIV);
    localparam int c_CNT_W = 16;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HDR_LAST = c_CNT_W'(SD_HDR_BITS - 1);
    localparam logic [c_CNT_W-1:0] c_CRC_LAST = c_CNT_W'(6);
    // Unreachable when GAP_BITS is zero: STOP then returns straight to IDLE.
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_BITS - 1);

    sd_state_e                r_state;
    sd_state_e                w_state_nxt;
    logic [c_DIV_W-1:0]       r_div;
    logic [c_CNT_W-1:0]       r_bit_cnt;
    logic [SD_HDR_BITS-1:0]   r_shreg;
    logic                     r_ready;
    logic                     r_done;
    logic [6:0]               r_crc_last;

    logic                     w_accept;
    logic                     w_tick;
    logic [6:0]               w_crc;
    logic [2:0]               w_crc_idx;
    logic                     w_crc_en;

    assign w_accept  = req.req_valid && r_ready && (r_state == IDLE);
    assign w_tick    = (r_state != IDLE) && (r_div == c_DIV_LAST);
    assign w_crc_idx = 3'd6 - r_bit_cnt[2:0];
    // Only header bits feed the CRC; the engine holds its value afterwards.
    assign w_crc_en  = (r_state == HDR) && w_tick;

    crc7_sync u_crc7 (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_accept),
        .en     (w_crc_en),
        .bit_in (r_shreg[SD_HDR_BITS-1]),
        .crc    (w_crc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and CMD line drive
    always_comb begin
        w_state_nxt = r_state;
        cmd_out     = 1'b1;
        cmd_oe      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = HDR;
            end
            HDR: begin
                cmd_oe  = 1'b1;
                cmd_out = r_shreg[SD_HDR_BITS-1];
                if (w_tick && (r_bit_cnt == c_HDR_LAST)) w_state_nxt = CRC;
            end
            CRC: begin
                cmd_oe  = 1'b1;
                cmd_out = w_crc[w_crc_idx];
                if (w_tick && (r_bit_cnt == c_CRC_LAST)) w_state_nxt = STOP;
            end
            STOP: begin
                cmd_oe  = 1'b1;
                cmd_out = 1'b1;
                if (w_tick) w_state_nxt = (GAP_BITS == 0) ? IDLE : GAP;
            end
            GAP: begin
                if (w_tick && (r_bit_cnt == c_GAP_LAST)) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Divider, bit counter, shift register and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_crc_last <= 7'h00;
        end else begin
            // Ready is registered from IDLE so it re-asserts one cycle after
            // the return to IDLE, keeping done and the next accept apart.
            r_ready <= (r_state == IDLE) && !w_accept;
            r_done  <= (r_state == STOP) && w_tick;

            if ((r_state == STOP) && w_tick) begin
                r_crc_last <= w_crc;
            end

            if (w_accept) begin
                r_shreg <= {2'b01, req.req_index, req.req_arg};
                r_div   <= '0;
            end else if (r_state != IDLE) begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if ((r_state == HDR) && w_tick) begin
                    r_shreg <= {r_shreg[SD_HDR_BITS-2:0], 1'b0};
                end
            end

            // Bit counter is local to each state.
            if (w_state_nxt != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_tick) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign req.req_ready = r_ready;
    assign busy          = (r_state != IDLE);
    assign done          = r_done;
    assign crc_last      = r_crc_last;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_cmd_tx
// Description : Directed self-checking bench for sd_cmd_tx. Instance A uses
//               CLK_DIV=4/GAP_BITS=8, instance B uses CLK_DIV=2/GAP_BITS=0.
//               Expected frames and CRCs are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_out, a_oe, a_busy, a_done;
    logic       b_out, b_oe, b_busy, b_done;
    logic [6:0] a_crc, b_crc;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_a    = 0;
    int done_a   = 0;

    sd_cmd_tx_if ifa ();
    sd_cmd_tx_if ifb ();

    always #5 clk = ~clk;

    sd_cmd_tx #(.CLK_DIV(4), .GAP_BITS(8)) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .req      (ifa),
        .cmd_out  (a_out),
        .cmd_oe   (a_oe),
        .busy     (a_busy),
        .done     (a_done),
        .crc_last (a_crc)
    );

    sd_cmd_tx #(.CLK_DIV(2), .GAP_BITS(0)) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .req      (ifb),
        .cmd_out  (b_out),
        .cmd_oe   (b_oe),
        .busy     (b_busy),
        .done     (b_done),
        .crc_last (b_crc)
    );

    // Accept and done counters for instance A
    always @(posedge clk) begin
        if (ifa.req_valid && ifa.req_ready) acc_a <= acc_a + 1;
        if (a_done) done_a <= done_a + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {ready, done, busy, oe, out}
    function automatic logic [4:0] sample(input int w);
        if (w == 0) return {ifa.req_ready, a_done, a_busy, a_oe, a_out};
        return {ifb.req_ready, b_done, b_busy, b_oe, b_out};
    endfunction

    function automatic logic [6:0] get_crc(input int w);
        return (w == 0) ? a_crc : b_crc;
    endfunction

    task automatic set_req(input int w, input logic v, input logic [5:0] idx, input logic [31:0] arg);
        if (w == 0) begin
            ifa.req_valid = v; ifa.req_index = idx; ifa.req_arg = arg;
        end else begin
            ifb.req_valid = v; ifb.req_index = idx; ifb.req_arg = arg;
        end
    endtask

    // Requests a command, waits for accept, then captures 48 bits (first
    // cycle of each bit) while checking hold/oe/busy, and follows the gap
    // until ready returns. Offsets count clk edges after the accept edge.
    task automatic run_frame(input int w, input logic [5:0] idx, input logic [31:0] arg,
                             input logic hold, input logic [5:0] nidx, input logic [31:0] narg,
                             output logic [47:0] frame, output logic [6:0] crcl,
                             output int acc_wait, output int done_off, output int ready_off,
                             output logic shape_ok);
        int d;
        logic [4:0] s;
        d = (w == 0) ? 4 : 2;
        frame = '0; crcl = '0; acc_wait = -1; done_off = -1; ready_off = -1; shape_ok = 1'b1;
        set_req(w, 1'b1, idx, arg);
        for (int i = 1; i <= 1000; i++) begin
            s = sample(w);
            @(posedge clk); #1;
            if (s[4]) begin acc_wait = i; break; end
        end
        if (acc_wait < 0) begin
            chk("accept_timeout", 64'd0, 64'd1);
            set_req(w, 1'b0, idx, arg);
            return;
        end
        set_req(w, hold, nidx, narg);
        for (int c = 0; c < 48 * d + 400; c++) begin
            s = sample(w);
            if (c < 48 * d) begin
                if (c % d == 0) frame[47 - c / d] = s[0];
                else if (s[0] !== frame[47 - c / d]) shape_ok = 1'b0;
                if (s[1] !== 1'b1 || s[2] !== 1'b1 || s[3] !== 1'b0) shape_ok = 1'b0;
            end else begin
                if (s[3] && done_off < 0) begin done_off = c; crcl = get_crc(w); end
                if (s[4]) begin ready_off = c; break; end
                if (s[1] !== 1'b0 || s[0] !== 1'b1) shape_ok = 1'b0;
            end
            @(posedge clk); #1;
        end
        if (ready_off < 0) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    logic [47:0] frame;
    logic [6:0]  crcl;
    int          acc_wait, done_off, ready_off;
    logic        shape_ok;
    logic [4:0]  s;
    int          done_before;

    initial begin
        rst = 1'b1;
        set_req(0, 1'b0, 6'd0, 32'd0);
        set_req(1, 1'b0, 6'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        s = sample(0);
        chk("rst_cmd_out", 64'(s[0]), 64'd1);
        chk("rst_cmd_oe", 64'(s[1]), 64'd0);
        chk("rst_busy", 64'(s[2]), 64'd0);
        chk("rst_done", 64'(s[3]), 64'd0);
        chk("rst_ready", 64'(s[4]), 64'd0);
        chk("rst_crc_last", 64'(a_crc), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(ifa.req_ready), 64'd1);

        // CMD0, arg 0
        run_frame(0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, frame, crcl, acc_wait, done_off, ready_off, shape_ok);
        chk("cmd0_frame", 64'(frame), 64'h400000000095);
        chk("cmd0_crc_last", 64'(crcl), 64'h4A);
        chk("cmd0_done_lat", 64'(done_off), 64'd192);
        chk("cmd0_ready_lat", 64'(ready_off), 64'd225);
        chk("cmd0_shape", 64'(shape_ok), 64'd1);

        // CMD8, arg 0x1AA
        run_frame(0, 6'd8, 32'h000001AA, 1'b0, 6'd8, 32'h000001AA, frame, crcl, acc_wait, done_off, ready_off, shape_ok);
        chk("cmd8_frame", 64'(frame), 64'h48000001AA87);
        chk("cmd8_crc_last", 64'(crcl), 64'h43);

        // CMD17 then CMD55 back-to-back with req_valid held high
        run_frame(0, 6'd17, 32'h0, 1'b1, 6'd55, 32'h0, frame, crcl, acc_wait, done_off, ready_off, shape_ok);
        chk("cmd17_frame", 64'(frame), 64'h510000000055);
        chk("cmd17_gap_after_done", 64'(ready_off - done_off), 64'd33);
        chk("cmd17_shape_gap", 64'(shape_ok), 64'd1);
        run_frame(0, 6'd55, 32'h0, 1'b0, 6'd55, 32'h0, frame, crcl, acc_wait, done_off, ready_off, shape_ok);
        chk("cmd55_accept_wait", 64'(acc_wait), 64'd1);
        chk("cmd55_frame", 64'(frame), 64'h770000000065);
        chk("cmd55_crc_last", 64'(crcl), 64'h32);

        // Reset in the middle of a CMD8 frame, at bit 20
        done_before = done_a;
        set_req(0, 1'b1, 6'd8, 32'h000001AA);
        acc_wait = -1;
        for (int i = 1; i <= 1000; i++) begin
            s = sample(0);
            @(posedge clk); #1;
            if (s[4]) begin acc_wait = i; break; end
        end
        chk("abort_accepted", 64'(acc_wait > 0), 64'd1);
        set_req(0, 1'b0, 6'd0, 32'h0);
        repeat (80) @(posedge clk);
        #1;
        chk("abort_pre_oe", 64'(a_oe), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        s = sample(0);
        chk("abort_cmd_out", 64'(s[0]), 64'd1);
        chk("abort_cmd_oe", 64'(s[1]), 64'd0);
        chk("abort_busy", 64'(s[2]), 64'd0);
        chk("abort_crc_last", 64'(a_crc), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", 64'(ifa.req_ready), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_a), 64'(done_before));

        // CMD0 after the abort
        run_frame(0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, frame, crcl, acc_wait, done_off, ready_off, shape_ok);
        chk("post_abort_frame", 64'(frame), 64'h400000000095);

        // CLK_DIV=2, GAP_BITS=0, CMD0
        run_frame(1, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, frame, crcl, acc_wait, done_off, ready_off, shape_ok);
        chk("div2_frame", 64'(frame), 64'h400000000095);
        chk("div2_done_lat", 64'(done_off), 64'd96);
        chk("div2_ready_lat", 64'(ready_off), 64'd97);
        chk("div2_shape", 64'(shape_ok), 64'd1);
        chk("div2_crc_last", 64'(crcl), 64'h4A);

        // Request held while busy, index/argument changed after accept
        run_frame(0, 6'd8, 32'h000001AA, 1'b1, 6'd17, 32'hDEADBEEF, frame, crcl, acc_wait, done_off, ready_off, shape_ok);
        set_req(0, 1'b0, 6'd0, 32'h0);
        chk("held_arg_frame", 64'(frame), 64'h48000001AA87);
        repeat (10) @(posedge clk);
        #1;
        // Seven accepts on A (one aborted), six completed frames.
        chk("accept_count", 64'(acc_a), 64'd7);
        chk("done_count", 64'(done_a), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
